// File: rtl/bus_line_fetcher.sv
// Instruction-line fetcher between the core front end and the Sysbus.
// Reads one aligned line per request, buffers it, then hands out
// instructions one at a time until the line is used up, a redirect
// arrives, or an all-zero instruction halts fetch.

`ifndef SYSBUS_READ
`define SYSBUS_READ 1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 1
`endif

module bus_line_fetcher #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8,
    parameter int INSN_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    output logic                      bus_reqcyc,
    input  logic                      bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      insn_valid,
    input  logic                      insn_ready,
    output logic [INSN_WIDTH-1:0]     insn_data,
    output logic [63:0]               insn_pc,
    output logic                      halted
);

    localparam int LINE_BYTES = BEATS * BUS_DATA_WIDTH / 8;
    localparam int INSN_BYTES = INSN_WIDTH / 8;
    localparam int INSNS      = BEATS * BUS_DATA_WIDTH / INSN_WIDTH;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int IB_W       = $clog2(INSN_BYTES);
    localparam int BEAT_W     = $clog2(BEATS) + 1;
    localparam int IDX_W      = $clog2(INSNS) + 1;
    localparam int TAG_INT    = (`SYSBUS_READ << 12) | (`SYSBUS_MEMORY << 8);
    localparam logic [BUS_TAG_WIDTH-1:0] READ_TAG = BUS_TAG_WIDTH'(TAG_INT);

    typedef enum logic [1:0] {REQ, RESP, DRAIN, HALT} state_t;

    state_t                                state, state_n;
    logic [63:0]                           line_addr, line_addr_n;
    logic [IDX_W-1:0]                      start_idx;
    logic [IDX_W-1:0]                      idx;
    logic [BEAT_W-1:0]                     beat_cnt;
    logic                                  discard;
    logic [BEATS-1:0][BUS_DATA_WIDTH-1:0]  beat_buf;
    logic [INSNS-1:0][INSN_WIDTH-1:0]      insn_view;
    logic [INSN_WIDTH-1:0]                 cur_insn;
    logic                                  accept, beat, last_beat;
    logic                                  fire, last_insn, zero_insn;
    logic                                  unused_ok;

    function automatic logic [63:0] line_of(input logic [63:0] a);
        return {a[63:OFF_W], {OFF_W{1'b0}}};
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [63:0] a);
        return {1'b0, a[OFF_W-1:IB_W]};
    endfunction

    // The line buffer read back as an array of instructions: beat 0 first,
    // low bits first within a beat.
    assign insn_view = beat_buf;
    assign cur_insn  = insn_view[idx[IDX_W-2:0]];

    assign accept    = (state == REQ) && bus_reqcyc && bus_reqack;
    assign beat      = (state == RESP) && bus_respcyc;
    assign last_beat = beat && (beat_cnt == BEAT_W'(BEATS - 1));
    assign zero_insn = (state == DRAIN) && (cur_insn == '0);
    assign fire      = insn_valid && insn_ready;
    assign last_insn = (idx == IDX_W'(INSNS - 1));

    // A redirect takes effect on the request address in the very next cycle.
    assign line_addr_n = redirect_valid ? line_of(redirect_pc) : line_addr;

    assign unused_ok = ^{bus_resptag, entry[IB_W-1:0], redirect_pc[IB_W-1:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= REQ;
        else       state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        unique case (state)
            REQ:   if (accept) state_n = RESP;
            RESP:  if (last_beat) state_n = (discard || redirect_valid) ? REQ : DRAIN;
            DRAIN: begin
                if (redirect_valid)          state_n = REQ;
                else if (zero_insn)          state_n = HALT;
                else if (fire && last_insn)  state_n = REQ;
            end
            HALT:  if (redirect_valid) state_n = REQ;
        endcase
    end

    // Instruction port; masked to zero outside DRAIN so reset shows clean values.
    always_comb begin
        insn_valid = 1'b0;
        insn_data  = '0;
        insn_pc    = '0;
        if (state == DRAIN && !zero_insn) begin
            insn_valid = 1'b1;
            insn_data  = cur_insn;
            insn_pc    = line_addr + (64'(idx) << IB_W);
        end
    end

    // Fetch control: addresses, counters, bus handshakes, halt flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_addr   <= line_of(entry);
            start_idx   <= idx_of(entry);
            beat_cnt    <= '0;
            idx         <= '0;
            discard     <= 1'b0;
            halted      <= 1'b0;
            bus_reqcyc  <= 1'b0;
            bus_req     <= '0;
            bus_reqtag  <= '0;
            bus_respack <= 1'b0;
        end else begin
            // Every beat is acked; beats outside RESP are stale and dropped.
            bus_respack <= bus_respcyc;

            if (redirect_valid) begin
                line_addr <= line_of(redirect_pc);
                start_idx <= idx_of(redirect_pc);
            end else if (state == DRAIN && fire && last_insn) begin
                line_addr <= line_addr + 64'(LINE_BYTES);
                start_idx <= '0;
            end

            if (state == REQ && !accept) begin
                bus_reqcyc <= 1'b1;
                bus_req    <= BUS_DATA_WIDTH'(line_addr_n);
                bus_reqtag <= READ_TAG;
            end else begin
                bus_reqcyc <= 1'b0;
            end

            if (accept)    beat_cnt <= '0;
            else if (beat) beat_cnt <= beat_cnt + 1'b1;

            // A line that was redirected away from is still fully absorbed.
            if (last_beat)
                discard <= 1'b0;
            else if (redirect_valid && (accept || state == RESP))
                discard <= 1'b1;

            if (last_beat)
                idx <= start_idx;
            else if (state == DRAIN && fire)
                idx <= idx + 1'b1;

            if (redirect_valid)
                halted <= 1'b0;
            else if (zero_insn)
                halted <= 1'b1;
        end
    end

    // Line buffer capture; contents are only meaningful once a line is complete.
    always_ff @(posedge clk) begin
        if (beat) beat_buf[beat_cnt[BEAT_W-2:0]] <= bus_resp;
    end

endmodule

// File: tb/tb_bus_line_fetcher.sv
// Randomized bench for bus_line_fetcher: a bus responder backed by a
// synthetic memory, and a reference model tracking the next expected pc.
module tb_bus_line_fetcher;

    localparam int BEATS = 8;
    localparam logic [12:0] RD_TAG = 13'h1100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] entry = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        bus_reqcyc;
    logic        bus_reqack;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_respcyc;
    logic        bus_respack;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag = '0;
    logic        insn_valid;
    logic        insn_ready = 1'b0;
    logic [31:0] insn_data;
    logic [63:0] insn_pc;
    logic        halted;

    bus_line_fetcher dut (
        .clk(clk), .reset(reset), .entry(entry),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_req(bus_req),
        .bus_reqtag(bus_reqtag), .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .insn_valid(insn_valid), .insn_ready(insn_ready), .insn_data(insn_data),
        .insn_pc(insn_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    // stimulus knobs
    int          ready_mode = 0;     // 0 always, 1 toggle, 2 random
    int          ack_dly = 2;
    bit          rand_ack = 0;
    bit          gaps = 0;
    logic [63:0] zero_addr = '1;
    bit          nx_reset = 1'b1, nx_redir = 1'b0;
    logic [63:0] nx_entry = '0, nx_pc = '0;

    // model / monitor state
    int          total = 0, bad = 0;
    logic [63:0] exp_pc = '0;
    int          n_insn = 0, n_req = 0, ack_cnt = 0, beats_seen = 0;
    int          cur_hold = 0, last_hold = 0;
    logic [63:0] last_req = '0, first_pc = '0;
    bit          got_first = 0;
    bit          p_valid = 0, p_ready = 0, p_redir = 0, p_rst = 1, p_respcyc = 0;
    bit          p_reqcyc = 0, p_accept = 0;
    logic [31:0] p_data = '0;
    logic [63:0] p_pc = '0, p_req = '0;
    logic [12:0] p_tag = '0;

    function automatic logic [31:0] word_at(input logic [63:0] a);
        if (a == zero_addr) return 32'h0;
        return (a[31:0] * 32'h9E3779B1) | 32'h1;
    endfunction

    function automatic logic [63:0] line_base(input logic [63:0] a);
        return a & ~64'h3F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sampled shortly before each rising edge, once all inputs are settled.
    task automatic monitor();
        if (reset) begin
            exp_pc = entry; n_insn = 0; n_req = 0; ack_cnt = 0; beats_seen = 0;
            cur_hold = 0; got_first = 0;
        end else begin
            chk("respack", bus_respack, p_respcyc && !p_rst);
            if (bus_respack) ack_cnt++;
            if (bus_respcyc) beats_seen++;
            if (p_valid && !p_ready && !p_redir && !p_rst) begin
                chk("stall_valid", insn_valid, 1);
                chk("stall_pc", insn_pc, p_pc);
                chk("stall_data", insn_data, p_data);
            end
            if (p_reqcyc && !p_accept && !p_redir && !p_rst) begin
                chk("req_hold_cyc", bus_reqcyc, 1);
                chk("req_hold_addr", bus_req, p_req);
                chk("req_hold_tag", bus_reqtag, p_tag);
            end
            if (bus_reqcyc) cur_hold++;
            if (bus_reqcyc && bus_reqack) begin
                chk("req_addr", bus_req, line_base(exp_pc));
                chk("req_tag", bus_reqtag, RD_TAG);
                last_req = bus_req; last_hold = cur_hold; cur_hold = 0; n_req++;
            end
            if (insn_valid) begin
                chk("insn_pc", insn_pc, exp_pc);
                chk("insn_data", insn_data, word_at(insn_pc));
                chk("zero_hidden", insn_pc == zero_addr, 0);
                if (insn_ready) begin
                    if (!got_first) begin first_pc = insn_pc; got_first = 1; end
                    n_insn++;
                    exp_pc += 64'd4;
                end
            end
            if (redirect_valid) begin exp_pc = redirect_pc; got_first = 0; end
        end
        p_valid = insn_valid; p_ready = insn_ready; p_pc = insn_pc; p_data = insn_data;
        p_reqcyc = bus_reqcyc; p_req = bus_req; p_tag = bus_reqtag;
        p_accept = bus_reqcyc && bus_reqack; p_respcyc = bus_respcyc;
        p_redir = redirect_valid; p_rst = reset;
    endtask

    task automatic step();
        @(negedge clk);
        reset = nx_reset; entry = nx_entry;
        redirect_valid = nx_redir; redirect_pc = nx_pc; nx_redir = 1'b0;
        case (ready_mode)
            0:       insn_ready = 1'b1;
            1:       insn_ready = !insn_ready;
            default: insn_ready = 1'($urandom_range(0, 1));
        endcase
        #2;
        monitor();
    endtask

    task automatic do_reset(input logic [63:0] e);
        nx_reset = 1'b1; nx_entry = e; step(); step();
        nx_reset = 1'b0; step();
    endtask

    task automatic wait_insns(input int n, input string tag);
        int k;
        k = 0;
        while (n_insn < n && k < 2000) begin step(); k++; end
        chk(tag, n_insn, n);
    endtask

    task automatic wait_req(input int n, input string tag);
        int k;
        k = 0;
        while (n_req < n && k < 2000) begin step(); k++; end
        chk(tag, n_req, n);
    endtask

    task automatic chk_rst_vals(input string p);
        chk({p, "_reqcyc"}, bus_reqcyc, 0);
        chk({p, "_respack"}, bus_respack, 0);
        chk({p, "_req"}, bus_req, 0);
        chk({p, "_tag"}, bus_reqtag, 0);
        chk({p, "_valid"}, insn_valid, 0);
        chk({p, "_data"}, insn_data, 0);
        chk({p, "_pc"}, insn_pc, 0);
        chk({p, "_halted"}, halted, 0);
    endtask

    // Bus responder: acks a request after a delay, then returns BEATS beats
    // of the addressed line from the synthetic memory.
    initial begin : responder
        int d;
        logic [63:0] raddr;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0;
        forever begin
            @(negedge clk);
            if (bus_reqcyc && !reset) begin
                d = rand_ack ? int'($urandom_range(0, 3)) : ack_dly;
                repeat (d) @(negedge clk);
                raddr = bus_req;
                bus_reqack = 1'b1;
                @(negedge clk);
                bus_reqack = 1'b0;
                for (int b = 0; b < BEATS; b++) begin
                    if (gaps)
                        while ($urandom_range(0, 2) == 0) begin
                            bus_respcyc = 1'b0;
                            @(negedge clk);
                        end
                    bus_respcyc = 1'b1;
                    bus_resp = {word_at(raddr + 64'(8 * b + 4)), word_at(raddr + 64'(8 * b))};
                    @(negedge clk);
                end
                bus_respcyc = 1'b0;
            end
        end
    end

    initial begin : main
        int k, quiet;
        // aligned entry, fixed ack delay, full line
        do_reset(64'h1000);
        chk_rst_vals("rst");
        wait_insns(16, "t1_insns");
        chk("t1_hold", last_hold, 3);
        chk("t1_acks", ack_cnt, 8);
        chk("t1_req0", last_req, 64'h1000);
        wait_req(2, "t1_nreq");
        chk("t1_next", last_req, 64'h1040);

        // mid-line entry
        rand_ack = 1;
        do_reset(64'h1008);
        wait_insns(14, "t2_insns");
        chk("t2_first", first_pc, 64'h1008);
        chk("t2_req0", last_req, 64'h1000);
        wait_req(2, "t2_nreq");
        chk("t2_next", last_req, 64'h1040);

        // consumer stalls every other cycle, gappy beats
        ready_mode = 1; gaps = 1;
        do_reset(64'h2000);
        wait_insns(40, "t3_insns");

        // zero instruction halts fetch
        ready_mode = 0; gaps = 0; zero_addr = 64'h1018;
        repeat (20) step();
        do_reset(64'h1000);
        k = 0;
        while (!halted && k < 300) begin step(); k++; end
        chk("t4_halted", halted, 1);
        chk("t4_count", n_insn, 6);
        chk("t4_valid", insn_valid, 0);
        quiet = 0;
        repeat (20) begin step(); if (bus_reqcyc) quiet++; end
        chk("t4_quiet", quiet, 0);
        nx_redir = 1'b1; nx_pc = 64'h2000;
        step(); step();
        chk("t4_unhalt", halted, 0);
        wait_req(2, "t4_nreq");
        chk("t4_req", last_req, 64'h2000);

        // redirect while beats are arriving
        zero_addr = '1; rand_ack = 0; ack_dly = 1;
        repeat (20) step();
        do_reset(64'h1000);
        k = 0;
        while (beats_seen < 3 && k < 300) begin step(); k++; end
        chk("t5_beats", beats_seen, 3);
        nx_redir = 1'b1; nx_pc = 64'h3040;
        wait_insns(1, "t5_insn");
        chk("t5_first", first_pc, 64'h3040);
        chk("t5_req", last_req, 64'h3040);
        chk("t5_nreq", n_req, 2);

        // reset in the middle of DRAIN
        ready_mode = 2;
        do_reset(64'h1000);
        wait_insns(5, "t6_insns");
        nx_reset = 1'b1; nx_entry = 64'h4000; step();
        nx_reset = 1'b0; step();
        chk_rst_vals("t6");
        wait_req(1, "t6_nreq");
        chk("t6_addr", last_req, 64'h4000);

        // random redirects, stalls, gaps and ack delays
        rand_ack = 1; gaps = 1;
        do_reset(64'($urandom_range(0, 65535)) & ~64'h3);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                nx_redir = 1'b1;
                nx_pc = 64'($urandom_range(0, 65535)) & ~64'h3;
            end
            step();
        end
        chk("t7_progress", n_insn > 50, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
